// File: rtl/hc_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hc_serial_pkg
// Description : Shared state encoding and default sizing for the serial link.
// Revision    : 1.0
// ============================================================================
package hc_serial_pkg;

    localparam int C_WIDTH_DEF = 8;
    localparam int C_DIV_DEF   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LATCH = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/hc_serial_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : hc_serial_tx_if
// Description : Word handshake plus serial link pins of hc_serial_tx.
// Revision    : 1.0
// ============================================================================
interface hc_serial_tx_if
    import hc_serial_pkg::*;
#(
    parameter int WIDTH = C_WIDTH_DEF
);
    logic             Valid;
    logic [WIDTH-1:0] Data;
    logic             Ready;
    logic             Busy;
    logic             SClk;
    logic             SD;
    logic             SLatch;

    modport slave (
        input  Valid, Data,
        output Ready, Busy, SClk, SD, SLatch
    );

    modport master (
        output Valid, Data,
        input  Ready, Busy, SClk, SD, SLatch
    );
endinterface
`default_nettype wire

// File: rtl/hc_piso_reg.sv
`default_nettype none
// ============================================================================
// Module      : hc_piso_reg
// Description : Parallel-load shift register; serial output is the next bit.
// Revision    : 1.0
// ============================================================================
module hc_piso_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic             Clk,
    input  wire logic             R,
    input  wire logic             load_i,
    input  wire logic             shift_i,
    input  wire logic [WIDTH-1:0] data_i,
    output logic                  sd_o
);
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] w_shifted;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_shifted = {sr_q[WIDTH-2:0], 1'b0};
            assign sd_o      = sr_q[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted = {1'b0, sr_q[WIDTH-1:1]};
            assign sd_o      = sr_q[0];
        end
    endgenerate

    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= data_i;
        end else if (shift_i) begin
            sr_q <= w_shifted;
        end
    end
endmodule
`default_nettype wire

// File: rtl/hc_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : hc_serial_tx
// Description : Handshaked word to SClk/SD/SLatch serial transmitter.
// Revision    : 1.0
// ============================================================================
module hc_serial_tx
    import hc_serial_pkg::*;
#(
    parameter int WIDTH     = C_WIDTH_DEF,
    parameter int DIV       = C_DIV_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic      Clk,
    input  wire logic      R,
    hc_serial_tx_if.slave  bus
);
    localparam int BW = $clog2(WIDTH + 1);
    // A one-cycle half-period still needs a 1-bit divider register.
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    state_t        state_q, state_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [DW-1:0] div_q, div_d;
    logic          sclk_q, sclk_d;
    logic          slatch_q, slatch_d;
    logic          w_load;
    logic          w_shift;
    logic          w_sd;

    always_ff @(posedge Clk or negedge R) begin
        if (!R) begin
            state_q  <= IDLE;
            bit_q    <= '0;
            div_q    <= '0;
            sclk_q   <= 1'b0;
            slatch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
            sclk_q   <= sclk_d;
            slatch_q <= slatch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        div_d   = div_q;
        w_load  = 1'b0;
        w_shift = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.Valid) begin
                    w_load  = 1'b1;
                    bit_d   = BW'(WIDTH);
                    div_d   = DW'(DIV - 1);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (div_q == '0) begin
                    div_d   = DW'(DIV - 1);
                    state_d = HIGH;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            HIGH: begin
                if (div_q != '0) begin
                    div_d = div_q - 1'b1;
                end else if (bit_q == BW'(1)) begin
                    state_d = LATCH;
                end else begin
                    // Shifting here moves SD on the SClk falling edge.
                    w_shift = 1'b1;
                    bit_d   = bit_q - 1'b1;
                    div_d   = DW'(DIV - 1);
                    state_d = SETUP;
                end
            end
            LATCH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        sclk_d   = (state_d == HIGH);
        slatch_d = (state_d == LATCH);
    end

    hc_piso_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .Clk     (Clk),
        .R       (R),
        .load_i  (w_load),
        .shift_i (w_shift),
        .data_i  (bus.Data),
        .sd_o    (w_sd)
    );

    assign bus.SClk   = sclk_q;
    assign bus.SD     = w_sd;
    assign bus.SLatch = slatch_q;
    assign bus.Ready  = (state_q == IDLE);
    assign bus.Busy   = (state_q != IDLE);
endmodule
`default_nettype wire

// File: doc/hc_serial_tx.md
Name: hc_serial_tx

Overview:
- Serial transmitter for the 74-series logic library.
- Accepts a parallel word over a valid/ready handshake and shifts it out on SD, paced by a generated serial clock SClk.
- Pulses SLatch once the word is complete.
- Drives the receiving end of the link: a shift chain built from HC_74-style D flip-flops, which sample SD on the SClk rising edge, plus an output latch strobed by SLatch.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- DIV, 2, Clk cycles per SClk half-period; must be >= 1.
- MSB_FIRST, 1, 1 = send bit WIDTH-1 first; 0 = send bit 0 first.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- R  input  1  reset; asynchronous, active-low.
- Valid  input  1  a word is offered on Data.
- Data  input  WIDTH  word to transmit; sampled only on the accept edge.
- Ready  output  1  transmitter idle and able to accept.
- SClk  output  1  serial clock to the receiver chain.
- SD  output  1  serial data.
- SLatch  output  1  one-cycle strobe: word complete, receiver latches its chain.
- Busy  output  1  inverse of Ready.

Behaviour:
- Reset (R=0, asynchronous, takes effect immediately regardless of Clk):
  - state=IDLE; SClk=0, SD=0, SLatch=0, Ready=1, Busy=0.
  - Shift register and counters cleared.
  - Valid is ignored while R=0.
- Reset mid-word: transfer aborted, no SLatch pulse, word discarded. After release the block sits in IDLE with outputs at reset values.
- All outputs are registered, except Ready and Busy, which decode the state register (Ready = state==IDLE).
- FSM states: IDLE, SETUP, HIGH, LATCH.
  - IDLE: SClk=0, SLatch=0. If Valid=1 at a rising edge, capture Data into the shift register, load bit counter with WIDTH and divider counter with DIV-1, then go to SETUP. Valid=0 stays in IDLE.
  - SETUP: SClk=0. SD holds the current bit: MSB of the shift register if MSB_FIRST=1, else LSB. Lasts exactly DIV cycles, then go to HIGH with the divider reloaded.
  - HIGH: SClk=1 for exactly DIV cycles; SD unchanged, so the receiver samples a stable bit.
    - On exit with bits remaining: shift by one, decrement the counter, go to SETUP.
    - On exit after the last bit: go to LATCH.
  - LATCH: SClk=0, SLatch=1 for exactly one cycle. SD holds the last bit. Then go to IDLE.
- SD changes only on the HIGH→SETUP transition (the SClk falling edge) and on the accept edge. It never changes while SClk=1.
- Latency:
  - The first SClk rising edge occurs DIV cycles after accept.
  - Ready is low for exactly 2*DIV*WIDTH+1 cycles per word; defaults give 33.
  - Ready returns high in the cycle after LATCH.
- Valid while Busy: ignored; Data is not sampled; no queueing.
- Back-to-back: if Valid is held high through LATCH, the next word is accepted on the first IDLE edge. Minimum word period is 2*DIV*WIDTH+2 cycles.
- Data may change freely after the accept edge without affecting the word in flight.
- Counters size to clog2(WIDTH+1) and clog2(DIV). No wrap-around: the counter is never decremented below 1 in HIGH; it is reloaded on accept.

Decomposition:
- Shared package hc_serial_pkg:
  - state encoding localparams: IDLE=2'd0, SETUP=2'd1, HIGH=2'd2, LATCH=2'd3;
  - default WIDTH and DIV constants, so the receiver-side bench model uses the same values.
- One sub-module, hc_piso_reg: WIDTH-bit parallel-load shift register. Inputs: load, shift, MSB_FIRST. Output: serial out. Same asynchronous active-low clear.
- The FSM and the divider counter stay in hc_serial_tx.

Test Plan:
- Reset: hold R=0 while Valid=1 and Data=8'hFF, and toggle Clk → SClk=0, SD=0, SLatch=0, Ready=1 throughout; no accept occurs after R rises until the next Valid edge.
- Single word, MSB_FIRST=1, DIV=2: send 8'hA5 → bits 1,0,1,0,0,1,0,1 on the 8 SClk rising edges; SLatch high for 1 cycle; Ready low for 33 cycles; a receiver chain of 8 HC_74-equivalent flops latches 8'hA5.
- LSB-first with DIV=1: MSB_FIRST=0, send 8'h01 → first sampled bit is 1, remaining seven are 0; Ready low for 17 cycles.
- Busy rejection: accept 8'h3C, then assert Valid with Data=8'hC3 mid-word → receiver gets 8'h3C only; exactly one SLatch pulse.
- Back-to-back: hold Valid high while offering 8'h12 then 8'h34 → two SLatch pulses 34 cycles apart; receiver shows 8'h12 then 8'h34.
- Reset mid-word: assert R=0 after the 3rd SClk rising edge → outputs drop to reset values within the same cycle; no SLatch; the next word 8'h5A transfers correctly.
